// File: rtl/aes_job_arbiter_if.sv
// Requester-side and core-side signal bundle of aes_job_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the core.
interface aes_job_arbiter_if #(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0]       req_valid;
   logic [128*N_REQ-1:0]   req_key;
   logic [128*N_REQ-1:0]   req_msg;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0]       rsp_valid;
   logic [N_REQ-1:0]       rsp_ack;
   logic [127:0]           rsp_data;
   logic                   rsp_err;
   logic                   aes_start;
   logic [127:0]           aes_key;
   logic [127:0]           aes_msg_enc;
   logic                   aes_done;
   logic [127:0]           aes_msg_dec;

   modport slave (
      input  req_valid, req_key, req_msg, rsp_ack, aes_done, aes_msg_dec,
      output req_ready, rsp_valid, rsp_data, rsp_err, aes_start, aes_key, aes_msg_enc
   );

   modport master (
      output req_valid, req_key, req_msg, rsp_ack, aes_done, aes_msg_dec,
      input  req_ready, rsp_valid, rsp_data, rsp_err, aes_start, aes_key, aes_msg_enc
   );
endinterface

// File: rtl/aes_job_arbiter.sv
// Round-robin owner of one AES decryption core: accepts a job, settles the key,
// runs the core's start/done handshake, returns the plaintext and releases the core.
module aes_job_arbiter #(
   parameter int N_REQ       = 2,
   parameter int KEY_SETTLE  = 12,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             CLK,
   input  logic             RESET,
   aes_job_arbiter_if.slave bus,
   output logic             busy,
   output logic [2:0]       grant_id
);
   localparam int CNT_MAX = (KEY_SETTLE > TIMEOUT_CYC) ? KEY_SETTLE : TIMEOUT_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_RESP, S_CLEANUP} state_t;

   state_t             state_q, state_d;
   logic [2:0]         ptr_q, ptr_d;
   logic [2:0]         grant_id_q, grant_id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               key_hit_q, key_hit_d;
   logic               last_key_valid_q, last_key_valid_d;
   logic [N_REQ-1:0]   req_ready_q, req_ready_d;
   logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [127:0]       key_q, key_d;
   logic [127:0]       msg_q, msg_d;
   logic [127:0]       rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               aes_start_q, aes_start_d;
   logic               busy_q, busy_d;

   logic [7:0]         valid_ext;
   logic [7:0]         ack_ext;
   logic [3:0]         scan;
   logic [2:0]         rr_idx;
   logic               rr_found;
   logic               acc_hit;
   logic [2:0]         acc_idx;
   logic [127:0]       acc_key;
   logic [127:0]       acc_msg;

   function automatic logic [N_REQ-1:0] onehot(input logic [2:0] idx);
      onehot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (3'(i) == idx) onehot[i] = 1'b1;
      end
   endfunction

   assign valid_ext = 8'(bus.req_valid);
   assign ack_ext   = 8'(bus.rsp_ack);

   // First requesting index at or after the pointer, wrapping modulo N_REQ.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      scan     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = {1'b0, ptr_q} + 4'(k);
         if (scan >= 4'(N_REQ)) scan = scan - 4'(N_REQ);
         if (!rr_found && valid_ext[scan[2:0]]) begin
            rr_found = 1'b1;
            rr_idx   = scan[2:0];
         end
      end
   end

   always_comb begin
      acc_hit = 1'b0;
      acc_idx = '0;
      acc_key = '0;
      acc_msg = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready_q[i] && bus.req_valid[i]) begin
            acc_hit = 1'b1;
            acc_idx = 3'(i);
            acc_key = bus.req_key[128*i +: 128];
            acc_msg = bus.req_msg[128*i +: 128];
         end
      end
   end

   always_comb begin
      // NOTE: every _d starts at its _q so no path through the case leaves a latch.
      state_d          = state_q;
      ptr_d            = ptr_q;
      grant_id_d       = grant_id_q;
      cnt_d            = cnt_q;
      key_hit_d        = key_hit_q;
      last_key_valid_d = last_key_valid_q;
      req_ready_d      = req_ready_q;
      rsp_valid_d      = rsp_valid_q;
      key_d            = key_q;
      msg_d            = msg_q;
      rsp_data_d       = rsp_data_q;
      rsp_err_d        = rsp_err_q;
      aes_start_d      = aes_start_q;

      unique case (state_q)
         S_IDLE: begin
            req_ready_d = '0;
            if (acc_hit) begin
               key_d      = acc_key;
               msg_d      = acc_msg;
               grant_id_d = acc_idx;
               ptr_d      = (acc_idx == 3'(N_REQ - 1)) ? 3'd0 : acc_idx + 3'd1;
               // key_q still holds the last loaded key whenever last_key_valid_q is set.
               key_hit_d  = last_key_valid_q && (acc_key == key_q);
               cnt_d      = '0;
               state_d    = S_LOAD;
            end else if (req_ready_q == '0 && rr_found) begin
               req_ready_d = onehot(rr_idx);
            end
         end
         S_LOAD: begin
            if (key_hit_q || cnt_q == CNT_W'(KEY_SETTLE - 1)) begin
               cnt_d            = '0;
               aes_start_d      = 1'b1;
               last_key_valid_d = 1'b1;
               state_d          = S_RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (bus.aes_done) begin
               rsp_data_d  = bus.aes_msg_dec;
               rsp_err_d   = 1'b0;
               rsp_valid_d = onehot(grant_id_q);
               state_d     = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               rsp_data_d       = '0;
               rsp_err_d        = 1'b1;
               rsp_valid_d      = onehot(grant_id_q);
               last_key_valid_d = 1'b0;
               state_d          = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (ack_ext[grant_id_q]) begin
               rsp_valid_d = '0;
               aes_start_d = 1'b0;
               state_d     = S_CLEANUP;
            end
         end
         S_CLEANUP: begin
            grant_id_d = '0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         // NOTE: key/msg/data registers drive ports directly, so they are reset as well.
         state_q          <= S_IDLE;
         ptr_q            <= '0;
         grant_id_q       <= '0;
         cnt_q            <= '0;
         key_hit_q        <= 1'b0;
         last_key_valid_q <= 1'b0;
         req_ready_q      <= '0;
         rsp_valid_q      <= '0;
         key_q            <= '0;
         msg_q            <= '0;
         rsp_data_q       <= '0;
         rsp_err_q        <= 1'b0;
         aes_start_q      <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling the same pre-edge values.
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         grant_id_q       <= grant_id_d;
         cnt_q            <= cnt_d;
         key_hit_q        <= key_hit_d;
         last_key_valid_q <= last_key_valid_d;
         req_ready_q      <= req_ready_d;
         rsp_valid_q      <= rsp_valid_d;
         key_q            <= key_d;
         msg_q            <= msg_d;
         rsp_data_q       <= rsp_data_d;
         rsp_err_q        <= rsp_err_d;
         aes_start_q      <= aes_start_d;
         busy_q           <= busy_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.aes_start   = aes_start_q;
   assign bus.aes_key     = key_q;
   assign bus.aes_msg_enc = msg_q;
   assign busy            = busy_q;
   assign grant_id        = grant_id_q;
endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
- Round-robin scheduler that shares one AES decryption core among N_REQ requesters, e.g. the software register interface and a DMA engine.
- Accepts a (key, ciphertext) job, sequences the core's start/done protocol, returns the plaintext to the owning requester, then releases the core.
- Sits between the requesters and the core's AES_START / AES_KEY / AES_MSG_ENC / AES_DONE / AES_MSG_DEC ports.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- KEY_SETTLE, 12, cycles the key/message are held with start low before start rises; covers the key-expansion latency.
- TIMEOUT_CYC, 64, maximum cycles in RUN without core done before the job is aborted.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester job request
- req_key  in  128*N_REQ  per-requester key; slice i is [128*i+127:128*i]
- req_msg  in  128*N_REQ  per-requester ciphertext, same slicing
- req_ready  out  N_REQ  one-hot acceptance pulse
- rsp_valid  out  N_REQ  one-hot result-valid flag
- rsp_ack  in  N_REQ  requester consumes its result
- rsp_data  out  128  plaintext for the current owner
- rsp_err  out  1  result is a timeout abort; qualified by rsp_valid
- aes_start  out  1  to core AES_START
- aes_key  out  128  to core AES_KEY
- aes_msg_enc  out  128  to core AES_MSG_ENC
- aes_done  in  1  from core AES_DONE
- aes_msg_dec  in  128  from core AES_MSG_DEC
- busy  out  1  high whenever state is not IDLE
- grant_id  out  3  index of the current owner; value is 0 in IDLE

Behaviour:
- Reset values: all outputs 0. State is IDLE, the round-robin pointer is 0 (requester 0 has top priority), and last_key_valid is 0.
- IDLE:
  - If any req_valid is high, grant the first requester at or after the pointer, wrapping modulo N_REQ.
  - Pulse req_ready[g] for exactly one cycle; acceptance is req_valid and req_ready both high.
  - On acceptance, capture req_key and req_msg into internal registers, set grant_id=g and pointer=(g+1) mod N_REQ, then go to LOAD.
- LOAD:
  - aes_start=0, so the core reloads its message register. aes_key and aes_msg_enc are driven from the captured registers and held stable until CLEANUP ends.
  - Stay KEY_SETTLE cycles, then go to RUN.
  - If last_key_valid=1 and the captured key equals the last loaded key, stay 1 cycle only.
  - On leaving LOAD, record the key as last loaded and set last_key_valid=1.
- RUN:
  - aes_start=1, held continuously.
  - A cycle counter starts at 0 and increments each RUN cycle.
  - If aes_done is high, capture aes_msg_dec into rsp_data, clear rsp_err, and go to RESP.
  - Else if the counter reaches TIMEOUT_CYC-1, set rsp_data=0 and rsp_err=1, go to RESP, and clear last_key_valid.
- RESP:
  - aes_start stays 1 so the core holds its result.
  - rsp_valid[grant_id]=1 until rsp_ack[grant_id] is high in the same cycle. Acks from other requesters are ignored.
  - After the ack, go to CLEANUP.
- CLEANUP: aes_start=0 for exactly 1 cycle so the core resets for the next job, then go to IDLE. grant_id returns to 0 in IDLE.
- Latency:
  - Acceptance in cycle T gives aes_start rising at T+1+KEY_SETTLE (or T+2 on a key hit).
  - aes_done sampled high in cycle D gives rsp_valid high in D+1.
- Boundaries:
  - Requesters with pending req_valid while busy get no req_ready; there is no queueing inside the block.
  - Dropping req_valid after acceptance has no effect on the job.
  - aes_done outside RUN is ignored.
  - rsp_ack held over several cycles counts once.
  - Back-to-back jobs from the same requester are allowed, but the pointer rotation gives the other requesters priority first.
  - RESET in any state: return to IDLE the next cycle, drop aes_start and rsp_valid, discard the job, and reset the pointer and last_key_valid.

Test Plan:
1. Single job: requester 0 sends key 000102030405060708090a0b0c0d0e0f and msg 69c4e0d86a7b0430d8cdb78070b4c55a -> req_ready[0] pulses once, aes_start rises 13 cycles after acceptance, rsp_valid[0] with rsp_data=00112233445566778899aabbccddeeff and rsp_err=0; after ack, aes_start is low for exactly 1 cycle.
2. Contention: req_valid=2'b11 held for 4 jobs -> grants go 0,1,0,1, and each job's rsp_valid appears only on its owner's bit.
3. Key cache: two consecutive jobs with the same key -> the second job's aes_start rises 2 cycles after acceptance; a third job with a different key waits 13 cycles.
4. Timeout: core model never asserts done -> after 64 RUN cycles, rsp_valid with rsp_err=1 and rsp_data=0; the next job with the same key waits the full 12 settle cycles.
5. Response backpressure: rsp_ack delayed 10 cycles, plus a spurious rsp_ack[1] during requester 0's response -> aes_start stays high and rsp_data is stable; the stray ack is ignored and the owner's ack completes the job.
6. RESET asserted during RUN -> next cycle busy=0, aes_start=0, rsp_valid=0; a new request from requester 1 is then granted after requester 0 (pointer reset to 0).
